// File: rtl/alu_seq.sv
// Registered ALU with handshake, persistent flags and optional shift-add multiply /
// restoring divide (compiled only when ALU_MULDIV_EN is defined).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       Opcode,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] ResHi,
    output logic             C,
    output logic             AC,
    output logic             Z,
    output logic             S,
    output logic             V,
    output logic             ERR
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBB = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd12;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd1, ST_ITER = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd1} state_t;
`endif

    // {carry/borrow, result} of a WIDTH+1 bit add or subtract
    function automatic logic [WIDTH:0] f_addsub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
        logic [WIDTH:0] ci;
        ci = {{WIDTH{1'b0}}, cin};
        if (sub)
            return {1'b0, a} - {1'b0, b} - ci;
        return {1'b0, a} + {1'b0, b} + ci;
    endfunction

    function automatic logic f_nibble(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic sub);
        logic [4:0] t;
        if (sub)
            t = {1'b0, a} - {1'b0, b} - {4'd0, cin};
        else
            t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        return t[4];
    endfunction

    function automatic logic f_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic sub);
        if (sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic [WIDTH-1:0] r_res, r_reshi;
    logic             r_c, r_ac, r_z, r_s, r_v, r_err;
    logic             r_busy, r_done;
`ifdef ALU_MULDIV_EN
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_madd, w_rsh, w_dif;
`endif

    logic             w_sub, w_cin, w_legal, w_wr;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res, w_hi;
    logic             w_c, w_ac, w_z, w_s, w_v, w_err;

`ifdef ALU_MULDIV_EN
    // One iteration of the shift-add multiplier and of the restoring divider
    always_comb begin
        w_madd = r_hi + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_rsh  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
        w_dif  = w_rsh - {1'b0, r_b};
    end
`endif

    always_comb begin
        w_sub   = (r_op == OP_SUB) || (r_op == OP_SBB) || (r_op == OP_CMP);
        w_cin   = r_c && ((r_op == OP_ADC) || (r_op == OP_SBB));
        w_sum   = f_addsub(r_a, r_b, w_cin, w_sub);
        w_res   = '0;
        w_hi    = '0;
        w_c     = 1'b0;
        w_ac    = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        w_legal = 1'b1;
        w_wr    = (r_op != OP_CMP);
        case (r_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_CMP: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_ac  = f_nibble(r_a[3:0], r_b[3:0], w_cin, w_sub);
                w_v   = f_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_sum[WIDTH-1], w_sub);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOT: w_res = ~r_a;
            OP_SHL: begin
                w_res = {r_a[WIDTH-2:0], 1'b0};
                w_c   = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                w_res = r_lo;
                w_hi  = r_hi[WIDTH-1:0];
                w_c   = |r_hi[WIDTH-1:0];
                w_v   = |r_hi[WIDTH-1:0];
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_res = '1;
                    w_hi  = r_a;
                    w_c   = 1'b1;
                    w_err = 1'b1;
                end else begin
                    w_res = r_lo;
                    w_hi  = r_hi[WIDTH-1:0];
                end
            end
`endif
            default: begin
                w_err   = 1'b1;
                w_legal = 1'b0;
                w_wr    = 1'b1;
            end
        endcase
`ifdef ALU_MULDIV_EN
        // The multiplier reports zero/sign over the full double-width product
        if (r_op == OP_MUL) begin
            w_z = ~|{w_hi, w_res};
            w_s = w_hi[WIDTH-1];
        end else begin
            w_z = w_legal && (w_res == '0);
            w_s = w_res[WIDTH-1];
        end
`else
        w_z = w_legal && (w_res == '0);
        w_s = w_res[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_reshi <= '0;
            r_c     <= 1'b0;
            r_ac    <= 1'b0;
            r_z     <= 1'b0;
            r_s     <= 1'b0;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= Opcode;
                        r_a     <= Op1;
                        r_b     <= Op2;
                        r_busy  <= 1'b1;
                        r_state <= ST_DONE;
`ifdef ALU_MULDIV_EN
                        r_hi    <= '0;
                        r_lo    <= Op1;
                        r_cnt   <= CW'(WIDTH - 1);
                        if (((Opcode == OP_MUL) || (Opcode == OP_DIV)) && (Op2 != '0))
                            r_state <= ST_ITER;
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                ST_ITER: begin
                    if (r_op == OP_MUL) begin
                        r_hi <= {1'b0, w_madd[WIDTH:1]};
                        r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
                    end else if (!w_dif[WIDTH]) begin
                        r_hi <= w_dif;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_rsh;
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0)
                        r_state <= ST_DONE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
`endif
                ST_DONE: begin
                    if (w_wr) begin
                        r_res   <= w_res;
                        r_reshi <= w_hi;
                    end
                    r_c     <= w_c;
                    r_ac    <= w_ac;
                    r_z     <= w_z;
                    r_s     <= w_s;
                    r_v     <= w_v;
                    r_err   <= w_err;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign Res   = r_res;
    assign ResHi = r_reshi;
    assign C     = r_c;
    assign AC    = r_ac;
    assign Z     = r_z;
    assign S     = r_s;
    assign V     = r_v;
    assign ERR   = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven and scoreboarded bench for alu_seq (WIDTH=8), including a
// reference model for randomized single-cycle operations.
module tb_alu_seq;

    logic       clk, rst, start;
    logic [3:0] Opcode;
    logic [7:0] Op1, Op2;
    logic       busy, done, C, AC, Z, S, V, ERR;
    logic [7:0] Res, ResHi;

    int n_vec = 0;
    int n_err = 0;

    logic [21:0] sb_q[$];
    logic        m_c;
    logic [7:0]  m_res, m_hi;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [21:0] exp;
        int          lat;
        int          glitch;
    } vec_t;

    vec_t tbl[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .Opcode(Opcode), .Op1(Op1), .Op2(Op2),
        .busy(busy), .done(done), .Res(Res), .ResHi(ResHi),
        .C(C), .AC(AC), .Z(Z), .S(S), .V(V), .ERR(ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] pk(input logic [7:0] r, input logic [7:0] h,
                                       input logic c, input logic ac, input logic z,
                                       input logic s, input logic v, input logic e);
        return {r, h, c, ac, z, s, v, e};
    endfunction

    function automatic logic [21:0] dut_out();
        return pk(Res, ResHi, C, AC, Z, S, V, ERR);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Independent integer model for the single-cycle opcodes
    function automatic logic [21:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ai, bi, sa, sb, sv, ci, r;
        logic c, ac, v;
        logic [7:0] rr;
        ai = int'(a);
        bi = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = ((op == 4'd8) || (op == 4'd9)) ? int'(m_c) : 0;
        c = 1'b0; ac = 1'b0; v = 1'b0; r = 0; sv = 0;
        case (op)
            4'd0, 4'd8: begin
                r  = ai + bi + ci;
                c  = (r > 255);
                ac = ((ai % 16) + (bi % 16) + ci) > 15;
                sv = sa + sb + ci;
                v  = (sv > 127) || (sv < -128);
            end
            4'd1, 4'd9, 4'd12: begin
                r  = ai - bi - ci;
                c  = (r < 0);
                ac = ((ai % 16) - (bi % 16) - ci) < 0;
                sv = sa - sb - ci;
                v  = (sv > 127) || (sv < -128);
            end
            4'd2: r = ai & bi;
            4'd3: r = ai | bi;
            4'd4: r = ai ^ bi;
            4'd5: r = 255 - ai;
            4'd6: begin r = ai * 2; c = (ai > 127); end
            4'd7: begin r = ai / 2; c = (ai % 2 == 1); end
            default: r = 0;
        endcase
        rr = r[7:0];
        if (op == 4'd12)
            return pk(m_res, m_hi, c, ac, rr == 8'h00, rr[7], v, 1'b0);
        return pk(rr, 8'h00, c, ac, rr == 8'h00, rr[7], v, 1'b0);
    endfunction

    // Caller is at a falling edge; returns at the falling edge where done was seen
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [21:0] exp, input int lat_exp,
                         input int glitch);
        int lat;
        logic [21:0] want;
        Opcode = op; Op1 = a; Op2 = b; start = 1'b1;
        sb_q.push_back(exp);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                Opcode = 4'($urandom); Op1 = 8'($urandom); Op2 = 8'($urandom);
                chk({tag, " busy after accept"}, 32'(busy), 32'd1);
            end
            if (glitch != 0) start = (lat == glitch);
        end while (!done && lat < 40);
        start = 1'b0;
        want = sb_q.pop_front();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, lat);
        end else begin
            chk({tag, " result"}, 32'(dut_out()), 32'(want));
            chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
            chk({tag, " busy at done"}, 32'(busy), 32'd0);
        end
        m_res = want[21:14];
        m_hi  = want[13:6];
        m_c   = want[5];
        if (glitch != 0) begin
            @(negedge clk);
            chk({tag, " no phantom op"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    logic [3:0] rops [0:10];

    initial begin
        int seen;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        rops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
        rst = 1'b1; start = 1'b0; Opcode = 4'd0; Op1 = 8'd0; Op2 = 8'd0;
        m_c = 1'b0; m_res = 8'd0; m_hi = 8'd0;

        tbl.push_back('{4'd0,  8'hF8, 8'h08, pk(8'h00, 8'h00, 1, 1, 1, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd1,  8'h00, 8'h08, pk(8'hF8, 8'h00, 1, 1, 0, 1, 0, 0), 2, 0});
        tbl.push_back('{4'd9,  8'h10, 8'h01, pk(8'h0E, 8'h00, 0, 1, 0, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd8,  8'h7F, 8'h00, pk(8'h7F, 8'h00, 0, 0, 0, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd0,  8'h7F, 8'h01, pk(8'h80, 8'h00, 0, 1, 0, 1, 1, 0), 2, 0});
        tbl.push_back('{4'd12, 8'h05, 8'h05, pk(8'h80, 8'h00, 0, 0, 1, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd2,  8'hF0, 8'h3C, pk(8'h30, 8'h00, 0, 0, 0, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd3,  8'h0F, 8'hF0, pk(8'hFF, 8'h00, 0, 0, 0, 1, 0, 0), 2, 0});
        tbl.push_back('{4'd4,  8'hAA, 8'hAA, pk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd5,  8'h00, 8'h55, pk(8'hFF, 8'h00, 0, 0, 0, 1, 0, 0), 2, 0});
        tbl.push_back('{4'd6,  8'h81, 8'h00, pk(8'h02, 8'h00, 1, 0, 0, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd7,  8'h01, 8'h00, pk(8'h00, 8'h00, 1, 0, 1, 0, 0, 0), 2, 0});
        tbl.push_back('{4'd14, 8'h12, 8'h34, pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1), 2, 0});
        tbl.push_back('{4'd0,  8'h01, 8'h01, pk(8'h02, 8'h00, 0, 0, 0, 0, 0, 0), 2, 0});
`ifdef ALU_MULDIV_EN
        tbl.push_back('{4'd10, 8'hFF, 8'hFF, pk(8'h01, 8'hFE, 1, 0, 0, 1, 1, 0), 10, 3});
        tbl.push_back('{4'd11, 8'd200, 8'd7, pk(8'd28, 8'd4, 0, 0, 0, 0, 0, 0), 10, 0});
        tbl.push_back('{4'd11, 8'h55, 8'h00, pk(8'hFF, 8'h55, 1, 0, 0, 1, 0, 1), 2, 0});
        tbl.push_back('{4'd10, 8'h00, 8'h37, pk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0), 10, 0});
        tbl.push_back('{4'd10, 8'h10, 8'h10, pk(8'h00, 8'h01, 1, 0, 0, 0, 1, 0), 10, 0});
`else
        tbl.push_back('{4'd10, 8'hFF, 8'hFF, pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1), 2, 0});
        tbl.push_back('{4'd11, 8'd200, 8'd7, pk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1), 2, 0});
`endif

        @(negedge clk);
        chk("reset state", {8'd0, busy, done, dut_out()}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            do_op($sformatf("vec%0d op%0d", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].exp, tbl[i].lat, tbl[i].glitch);

        // Abort an operation in flight with an asynchronous reset
        do_op("pre-abort add", 4'd0, 8'h7F, 8'h01, pk(8'h80, 8'h00, 0, 1, 0, 1, 1, 0), 2, 0);
`ifdef ALU_MULDIV_EN
        Opcode = 4'd10;
`else
        Opcode = 4'd0;
`endif
        Op1 = 8'hFF; Op2 = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef ALU_MULDIV_EN
        repeat (2) @(negedge clk);
`endif
        #2 rst = 1'b1;
        #1 chk("async abort clears outputs", {8'd0, busy, done, dut_out()}, 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no done after abort", 32'(seen), 32'd0);
        m_c = 1'b0; m_res = 8'd0; m_hi = 8'd0;
        do_op("add after abort", 4'd0, 8'h01, 8'h01, pk(8'h02, 8'h00, 0, 0, 0, 0, 0, 0), 2, 0);

        for (int i = 0; i < 40; i++) begin
            rop = rops[$urandom_range(10)];
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if (i % 8 == 0) rb = ra;
            do_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
                  model(rop, ra, rb), 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
